// File: rtl/multimode_shiftreg_pkg.sv
// Shared definitions for the multimode shift register: mode encodings and sizing helpers.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/multimode_shiftreg_if.sv
// Control/data bundle between a shift-register client and multimode_shiftreg.
interface multimode_shiftreg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             peripheralClkEdge;
    logic [1:0]       mode;
    logic             msbFirst;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
    logic [WIDTH-1:0] parallelDataOut;
    logic             serialDataOut;
    logic [CNT_W-1:0] bitCount;
    logic             wordDone;

    modport master (
        output peripheralClkEdge, mode, msbFirst, parallelDataIn, serialDataIn,
        input  parallelDataOut, serialDataOut, bitCount, wordDone
    );

    modport slave (
        input  peripheralClkEdge, mode, msbFirst, parallelDataIn, serialDataIn,
        output parallelDataOut, serialDataOut, bitCount, wordDone
    );
endinterface

// File: rtl/multimode_shiftreg_counter.sv
// Counts shift/rotate operations within a word; wrap pulses for one cycle after the last bit.
module shift_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);
    import shiftreg_pkg::*;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_r;
    logic             wrap_r;

    // Bit counter and word-complete pulse; clear takes priority over inc.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            wrap_r  <= 1'b0;
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
            wrap_r  <= 1'b0;
        end else if (inc) begin
            if (count_r == LAST_BIT) begin
                count_r <= {CNT_W{1'b0}};
                wrap_r  <= 1'b1;
            end else begin
                count_r <= count_r + CNT_W'(1);
                wrap_r  <= 1'b0;
            end
        end else begin
            count_r <= count_r;
            wrap_r  <= 1'b0;
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;

endmodule

// File: rtl/multimode_shiftreg.sv
// Shift register with hold / shift / parallel-load / rotate modes, gated by a peripheral edge strobe.
module multimode_shiftreg #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                 clk,
    input logic                 reset,
    multimode_shiftreg_if.slave bus
);
    import shiftreg_pkg::*;

    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic             clear_s;
    logic             inc_s;
    mode_e            mode_s;
    logic [CNT_W-1:0] count_s;
    logic             wrap_s;

    assign mode_s = mode_e'(bus.mode);

    // Next register value and counter controls for the strobed operation.
    always_comb begin
        shreg_nxt_s = shreg_r;
        clear_s     = 1'b0;
        inc_s       = 1'b0;
        if (bus.peripheralClkEdge) begin
            case (mode_s)
                MODE_HOLD: begin
                    shreg_nxt_s = shreg_r;
                end
                MODE_SHIFT: begin
                    inc_s = 1'b1;
                    if (bus.msbFirst) begin
                        shreg_nxt_s = {shreg_r[WIDTH-2:0], bus.serialDataIn};
                    end else begin
                        shreg_nxt_s = {bus.serialDataIn, shreg_r[WIDTH-1:1]};
                    end
                end
                MODE_LOAD: begin
                    clear_s     = 1'b1;
                    shreg_nxt_s = bus.parallelDataIn;
                end
                MODE_ROTATE: begin
                    inc_s = 1'b1;
                    if (bus.msbFirst) begin
                        shreg_nxt_s = {shreg_r[WIDTH-2:0], shreg_r[WIDTH-1]};
                    end else begin
                        shreg_nxt_s = {shreg_r[0], shreg_r[WIDTH-1:1]};
                    end
                end
                default: begin
                    shreg_nxt_s = shreg_r;
                end
            endcase
        end else begin
            shreg_nxt_s = shreg_r;
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
        end else begin
            shreg_r <= shreg_nxt_s;
        end
    end

    shift_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .inc   (inc_s),
        .count (count_s),
        .wrap  (wrap_s)
    );

    // Serial output follows msbFirst without waiting for an edge.
    assign bus.parallelDataOut = shreg_r;
    assign bus.serialDataOut   = bus.msbFirst ? shreg_r[WIDTH-1] : shreg_r[0];
    assign bus.bitCount        = count_s;
    assign bus.wordDone        = wrap_s;

endmodule

// File: tb/tb_multimode_shiftreg.sv
// Directed self-checking bench for multimode_shiftreg at WIDTH=8.
module tb_multimode_shiftreg;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SHIFT = 2'b01;
    localparam logic [1:0] M_LOAD = 2'b10;
    localparam logic [1:0] M_ROT = 2'b11;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    multimode_shiftreg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    multimode_shiftreg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic msb,
                        input logic [7:0] pd, input logic s);
        bus.peripheralClkEdge = e;
        bus.mode              = m;
        bus.msbFirst          = msb;
        bus.parallelDataIn    = pd;
        bus.serialDataIn      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] pout, input logic sout,
                             input logic [3:0] cnt, input logic wd);
        check({tag, ".pout"}, 64'(bus.parallelDataOut), 64'(pout));
        check({tag, ".sout"}, 64'(bus.serialDataOut), 64'(sout));
        check({tag, ".cnt"}, 64'(bus.bitCount), 64'(cnt));
        check({tag, ".wd"}, 64'(bus.wordDone), 64'(wd));
    endtask

    logic [7:0] shift_bits;

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        bus.peripheralClkEdge = 1'b0;
        bus.mode              = M_HOLD;
        bus.msbFirst          = 1'b1;
        bus.parallelDataIn    = 8'h00;
        bus.serialDataIn      = 1'b0;
        @(negedge clk);

        // Reset overrides a simultaneous shift edge
        step(1'b1, M_SHIFT, 1'b1, 8'hFF, 1'b1);
        check_all("reset", 8'h00, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;

        // Load 0xA5
        step(1'b1, M_LOAD, 1'b1, 8'hA5, 1'b0);
        check_all("load_a5", 8'hA5, 1'b1, 4'd0, 1'b0);

        // MSB-first shift 1,0,1,1,0,0,1,0 from 0x00 -> 0xB2
        step(1'b1, M_LOAD, 1'b1, 8'h00, 1'b0);
        shift_bits = 8'b1011_0010;
        for (int i = 0; i < 7; i++) step(1'b1, M_SHIFT, 1'b1, 8'h00, shift_bits[7-i]);
        check_all("shift7", 8'h59, 1'b0, 4'd7, 1'b0);
        step(1'b1, M_SHIFT, 1'b1, 8'h00, shift_bits[0]);
        check_all("shift8", 8'hB2, 1'b1, 4'd0, 1'b1);
        step(1'b0, M_HOLD, 1'b1, 8'h00, 1'b0);
        check_all("after_wd", 8'hB2, 1'b1, 4'd0, 1'b0);

        // LSB-first rotate of 0x81
        step(1'b1, M_LOAD, 1'b0, 8'h81, 1'b0);
        step(1'b1, M_ROT, 1'b0, 8'h00, 1'b1);
        check_all("rot1", 8'hC0, 1'b0, 4'd1, 1'b0);
        bus.msbFirst = 1'b1;
        #1;
        check("msb_toggle.sout", 64'(bus.serialDataOut), 64'(1'b1));
        check("msb_toggle.pout", 64'(bus.parallelDataOut), 64'h00C0);
        bus.msbFirst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, M_ROT, 1'b0, 8'h00, 1'b1);
        check_all("rot7", 8'h03, 1'b1, 4'd7, 1'b0);
        step(1'b1, M_ROT, 1'b0, 8'h00, 1'b0);
        check_all("rot8", 8'h81, 1'b1, 4'd0, 1'b1);

        // Load mid-word restarts the count
        step(1'b1, M_LOAD, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, M_SHIFT, 1'b1, 8'h00, 1'b1);
        check_all("shift5", 8'h1F, 1'b0, 4'd5, 1'b0);
        step(1'b1, M_LOAD, 1'b0, 8'h3C, 1'b0);
        check_all("load_3c", 8'h3C, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, M_SHIFT, 1'b0, 8'h00, 1'b1);
        check_all("post_load7", 8'hFE, 1'b0, 4'd7, 1'b0);
        step(1'b1, M_SHIFT, 1'b0, 8'h00, 1'b1);
        check_all("post_load8", 8'hFF, 1'b1, 4'd0, 1'b1);

        // Load at bitCount=WIDTH-1 suppresses wordDone
        step(1'b1, M_LOAD, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, M_SHIFT, 1'b1, 8'h00, 1'b0);
        check("pre_prio.cnt", 64'(bus.bitCount), 64'd7);
        step(1'b1, M_LOAD, 1'b1, 8'h5A, 1'b0);
        check_all("load_prio", 8'h5A, 1'b0, 4'd0, 1'b0);
        step(1'b0, M_SHIFT, 1'b1, 8'h00, 1'b0);
        check_all("load_prio_next", 8'h5A, 1'b0, 4'd0, 1'b0);

        // Interleaved idle cycles
        step(1'b1, M_LOAD, 1'b1, 8'h00, 1'b0);
        step(1'b1, M_SHIFT, 1'b1, 8'h00, 1'b1);
        check_all("il_shift1", 8'h01, 1'b0, 4'd1, 1'b0);
        step(1'b0, M_SHIFT, 1'b1, 8'h00, 1'b1);
        check_all("il_noedge", 8'h01, 1'b0, 4'd1, 1'b0);
        step(1'b1, M_HOLD, 1'b1, 8'h00, 1'b1);
        check_all("il_hold", 8'h01, 1'b0, 4'd1, 1'b0);
        step(1'b1, M_SHIFT, 1'b1, 8'h00, 1'b1);
        check_all("il_shift2", 8'h03, 1'b0, 4'd2, 1'b0);
        step(1'b0, M_ROT, 1'b1, 8'h00, 1'b0);
        step(1'b0, M_LOAD, 1'b1, 8'hFF, 1'b0);
        check_all("il_noedge_load", 8'h03, 1'b0, 4'd2, 1'b0);

        // Reset mid-word with a shift edge in the same cycle
        step(1'b1, M_LOAD, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, M_SHIFT, 1'b1, 8'h00, 1'b1);
        check_all("pre_reset", 8'h3F, 1'b0, 4'd6, 1'b0);
        reset = 1'b1;
        step(1'b1, M_SHIFT, 1'b1, 8'h00, 1'b1);
        reset = 1'b0;
        check_all("mid_reset", 8'h00, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, M_SHIFT, 1'b1, 8'h00, 1'b1);
        check_all("post_reset7", 8'h7F, 1'b0, 4'd7, 1'b0);
        step(1'b1, M_SHIFT, 1'b1, 8'h00, 1'b1);
        check_all("post_reset8", 8'hFF, 1'b1, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multimode_shiftreg.md
MULTIMODE_SHIFTREG -- requirements
Module: multimode_shiftreg

Interface
REQ-001 SHALL have parameter: WIDTH, 8, register length in bits; legal range 2..64.
REQ-002 SHALL have derived localparam: CNT_W, clog2(WIDTH+1), bit-counter width.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: peripheralClkEdge  input  1  one-cycle enable strobe; mode acts only when it is high.
REQ-006 SHALL have port: mode  input  2  operation: 00 hold, 01 shift, 10 parallel load, 11 rotate.
REQ-007 SHALL have port: msbFirst  input  1  direction: 1 shift toward MSB, 0 toward LSB.
REQ-008 SHALL have port: parallelDataIn  input  WIDTH  parallel load value.
REQ-009 SHALL have port: serialDataIn  input  1  bit entering on shift.
REQ-010 SHALL have port: parallelDataOut  output  WIDTH  full register contents.
REQ-011 SHALL have port: serialDataOut  output  1  outgoing bit: MSB when msbFirst=1, else LSB.
REQ-012 SHALL have port: bitCount  output  CNT_W  shifts/rotates since last load or wrap.
REQ-013 SHALL have port: wordDone  output  1  one-cycle pulse when WIDTH shifts complete.

Function
REQ-014 SHALL update register, bitCount and wordDone only on rising clk; no other storage.
REQ-015 SHALL leave register and bitCount unchanged when peripheralClkEdge=0 or mode=00.
REQ-016 SHALL, on edge with mode=10, load parallelDataIn and clear bitCount to 0.
REQ-017 SHALL, on edge with mode=01 and msbFirst=1, set reg to {reg[WIDTH-2:0], serialDataIn}.
REQ-018 SHALL, on edge with mode=01 and msbFirst=0, set reg to {serialDataIn, reg[WIDTH-1:1]}.
REQ-019 SHALL, on edge with mode=11, rotate in chosen direction; outgoing bit re-enters the vacated end; serialDataIn ignored.
REQ-020 SHALL increment bitCount by 1 on each shift or rotate edge.
REQ-021 SHALL, when a shift/rotate edge finds bitCount=WIDTH-1, set bitCount to 0 and assert wordDone next cycle for exactly one cycle.
REQ-022 SHALL deassert wordDone on every cycle not covered by REQ-021, including load and hold edges.
REQ-023 SHALL drive parallelDataOut and serialDataOut combinationally from the register; new values visible the cycle after the edge.
REQ-024 SHALL let msbFirst change between edges; serialDataOut follows msbFirst immediately, register unaffected.
REQ-025 SHALL give load priority: mode=10 clears a pending count even at bitCount=WIDTH-1, with no wordDone.
REQ-026 SHALL treat back-to-back edge cycles as independent operations, one per cycle, no dropped strobes.

Reset
REQ-027 SHALL, when reset=1 at a rising clk, clear register, bitCount and wordDone to 0, overriding all other inputs.
REQ-028 SHALL, on reset mid-word, discard partial shifts; first post-reset wordDone requires WIDTH new shifts.
REQ-029 SHALL hold parallelDataOut=0, serialDataOut=0, bitCount=0, wordDone=0 on the cycle after reset.

Structure
REQ-030 SHALL take mode encodings (MODE_HOLD, MODE_SHIFT, MODE_LOAD, MODE_ROTATE) from shared package shiftreg_pkg.
REQ-031 SHALL implement the counter/wordDone logic in one sub-module, shift_bit_counter (inputs: clk, reset, clear, inc; outputs: count, wrap).
REQ-032 SHALL contain no input conditioning; peripheralClkEdge arrives already synchronised and single-cycle.

Verification
REQ-033 SHALL cover: WIDTH=8, reset, load 0xA5 -> parallelDataOut=0xA5, bitCount=0, serialDataOut=1 (msbFirst=1).
REQ-034 SHALL cover: msbFirst=1, shift serial 1,0,1,1,0,0,1,0 from 0x00 -> 0xB2; wordDone high one cycle after 8th edge; bitCount=0.
REQ-035 SHALL cover: load 0x81, msbFirst=0, rotate 1 edge -> 0xC0; after 8 rotates -> 0x81 with wordDone pulse.
REQ-036 SHALL cover: 5 shifts, then load 0x3C -> bitCount=0, no wordDone; 8 more shifts needed for wordDone.
REQ-037 SHALL cover: shifts with peripheralClkEdge=0 or mode=00 interleaved -> register and bitCount unchanged on those cycles.
REQ-038 SHALL cover: reset asserted after 6 shifts with mode=01 edge same cycle -> all outputs 0, no wordDone.
